// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory request path.
package core_pkg;

   localparam int ICACHE_ID_BIT           = 6;
   localparam int ACCESS_ID_W             = ICACHE_ID_BIT + 1;
   localparam int ADDR_W                  = 32;
   localparam int DATA_W                  = 32;
   localparam int MEM_REQ_PER_CORE        = 2;
   localparam int DEFAULT_MAX_OUTSTANDING = 64;
   localparam int DEFAULT_STARVE_LIMIT    = 8;

   // access_id: bit ICACHE_ID_BIT marks an icache transaction, low bits are the requester tag
   typedef struct packed {
      logic                   vld;
      logic                   we;
      logic [ACCESS_ID_W-1:0] access_id;
      logic [ADDR_W-1:0]      addr;
      logic [DATA_W-1:0]      data;
   } request_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic logic is_icache_id(input logic [ACCESS_ID_W-1:0] id);
      return id[ICACHE_ID_BIT];
   endfunction

endpackage

// File: rtl/mem_rsp_router.sv
// Registered response demux (icache vs LSU) with sticky underflow detection.
module mem_rsp_router
   import core_pkg::*;
(
   input  logic     clk_i,
   input  logic     reset_i,
   input  request_t mem_rsp_i,
   input  logic     cnt_zero_i,
   output request_t icache_rsp_o,
   output request_t lsu_rsp_o,
   output logic     underflow_o
);

   request_t icache_rsp_q;
   request_t lsu_rsp_q;
   logic     underflow_q;

   // Route each response one cycle later; the unused side and idle cycles read as zero
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         icache_rsp_q <= '0;
         lsu_rsp_q    <= '0;
         underflow_q  <= 1'b0;
      end else begin
         icache_rsp_q <= '0;
         lsu_rsp_q    <= '0;
         if (mem_rsp_i.vld) begin
            if (is_icache_id(mem_rsp_i.access_id)) begin
               icache_rsp_q <= mem_rsp_i;
            end else begin
               lsu_rsp_q <= mem_rsp_i;
            end
            if (cnt_zero_i) begin
               underflow_q <= 1'b1;
            end
         end
      end
   end

   assign icache_rsp_o = icache_rsp_q;
   assign lsu_rsp_o    = lsu_rsp_q;
   assign underflow_o  = underflow_q;

endmodule

// File: rtl/core_mem_port_scheduler.sv
// Shares the single memory request port between icache and LSU: weighted
// arbitration, a one-entry output slot, outstanding tracking and response routing.
module core_mem_port_scheduler
   import core_pkg::*;
#(
   parameter  int STARVE_LIMIT    = DEFAULT_STARVE_LIMIT,
   parameter  int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  request_t         icache_mem_req,
   output logic             icache_req_grant,
   input  request_t         lsu_mem_req,
   output logic             lsu_req_grant,
   output request_t         mem_req,
   input  logic             mem_req_grant,
   input  request_t         mem_rsp,
   output request_t         icache_mem_rsp,
   output request_t         lsu_mem_rsp,
   output logic [CNT_W-1:0] outstanding_cnt,
   output logic             rsp_underflow
);

   localparam int               STV_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

   slot_state_t      state_q;
   request_t         mem_req_q;
   logic [STV_W-1:0] starve_q, starve_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lsu_win, icache_win, accept, can_load;

   // Winner selection and load qualification; grants are forced low while in reset
   always_comb begin
      lsu_win    = lsu_mem_req.vld && (!icache_mem_req.vld || (starve_q == STV_MAX));
      icache_win = icache_mem_req.vld && !lsu_win;
      accept     = (state_q == SLOT_FULL) && mem_req_grant;
      can_load   = ((state_q == SLOT_EMPTY) || accept) && (cnt_q < CNT_MAX) && !reset;
   end

   assign icache_req_grant = icache_win && can_load;
   assign lsu_req_grant    = lsu_win && can_load;

   // Slot FSM: hold the request until the fabric takes it, reload without a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SLOT_EMPTY;
         mem_req_q <= '0;
      end else begin
         case (state_q)
            SLOT_EMPTY: begin
               if (lsu_req_grant) begin
                  state_q   <= SLOT_FULL;
                  mem_req_q <= lsu_mem_req;
               end else if (icache_req_grant) begin
                  state_q   <= SLOT_FULL;
                  mem_req_q <= icache_mem_req;
               end
            end
            SLOT_FULL: begin
               if (mem_req_grant) begin
                  if (lsu_req_grant) begin
                     mem_req_q <= lsu_mem_req;
                  end else if (icache_req_grant) begin
                     mem_req_q <= icache_mem_req;
                  end else begin
                     state_q   <= SLOT_EMPTY;
                     mem_req_q <= '0;
                  end
               end
            end
            default: begin
               state_q   <= SLOT_EMPTY;
               mem_req_q <= '0;
            end
         endcase
      end
   end

   // Next-state for the starve and outstanding counters
   always_comb begin
      starve_d = starve_q;
      if (!lsu_mem_req.vld || lsu_req_grant) begin
         starve_d = '0;
      end else if (icache_req_grant && (starve_q != STV_MAX)) begin
         starve_d = starve_q + STV_W'(1);
      end

      cnt_d = cnt_q;
      if (accept && !mem_rsp.vld) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (!accept && mem_rsp.vld) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
         cnt_q    <= '0;
      end else begin
         starve_q <= starve_d;
         cnt_q    <= cnt_d;
      end
   end

   mem_rsp_router u_rsp_router (
      .clk_i        (clk),
      .reset_i      (reset),
      .mem_rsp_i    (mem_rsp),
      .cnt_zero_i   (cnt_q == '0),
      .icache_rsp_o (icache_mem_rsp),
      .lsu_rsp_o    (lsu_mem_rsp),
      .underflow_o  (rsp_underflow)
   );

   assign mem_req         = mem_req_q;
   assign outstanding_cnt = cnt_q;

endmodule

// File: tb/tb_core_mem_port_scheduler.sv
// Directed bench for core_mem_port_scheduler with a queue-based reference model.
module tb_core_mem_port_scheduler;
   import core_pkg::*;

   localparam int STARVE_LIMIT = 8;
   localparam int MAX_OUT      = 4;
   localparam int CNT_W        = $clog2(MAX_OUT + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   request_t         icache_mem_req = '0;
   request_t         lsu_mem_req = '0;
   request_t         mem_rsp = '0;
   logic             mem_req_grant = 1'b0;
   request_t         mem_req, icache_mem_rsp, lsu_mem_rsp;
   logic             icache_req_grant, lsu_req_grant, rsp_underflow;
   logic [CNT_W-1:0] outstanding_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   core_mem_port_scheduler #(
      .STARVE_LIMIT    (STARVE_LIMIT),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .icache_mem_req   (icache_mem_req),
      .icache_req_grant (icache_req_grant),
      .lsu_mem_req      (lsu_mem_req),
      .lsu_req_grant    (lsu_req_grant),
      .mem_req          (mem_req),
      .mem_req_grant    (mem_req_grant),
      .mem_rsp          (mem_rsp),
      .icache_mem_rsp   (icache_mem_rsp),
      .lsu_mem_rsp      (lsu_mem_rsp),
      .outstanding_cnt  (outstanding_cnt),
      .rsp_underflow    (rsp_underflow)
   );

   function automatic request_t mk(input logic we, input logic [6:0] id,
                                   input logic [31:0] addr, input logic [31:0] data);
      request_t r;
      r.vld       = 1'b1;
      r.we        = we;
      r.access_id = id;
      r.addr      = addr;
      r.data      = data;
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Reference model: slot as a queue, counters as plain integers
   request_t m_slot[$];
   int       m_starve = 0;
   int       m_out    = 0;
   bit       m_uflow  = 0;
   request_t m_ic_rsp  = '0;
   request_t m_lsu_rsp = '0;

   always @(negedge clk) begin
      request_t exp_req;
      bit acc, free, pick_l, pick_i, exp_ig, exp_lg, dec;
      if (reset) begin
         m_slot.delete();
         m_starve  = 0;
         m_out     = 0;
         m_uflow   = 0;
         m_ic_rsp  = '0;
         m_lsu_rsp = '0;
      end
      exp_req = (m_slot.size() != 0) ? m_slot[0] : '0;
      acc     = (m_slot.size() != 0) && mem_req_grant;
      free    = (m_slot.size() == 0) || acc;
      pick_l  = lsu_mem_req.vld && (!icache_mem_req.vld || m_starve >= STARVE_LIMIT);
      pick_i  = icache_mem_req.vld && !pick_l;
      exp_ig  = !reset && free && (m_out < MAX_OUT) && pick_i;
      exp_lg  = !reset && free && (m_out < MAX_OUT) && pick_l;

      check("mdl_icache_grant", icache_req_grant, exp_ig);
      check("mdl_lsu_grant", lsu_req_grant, exp_lg);
      check("mdl_mem_req", mem_req, exp_req);
      check("mdl_icache_rsp", icache_mem_rsp, m_ic_rsp);
      check("mdl_lsu_rsp", lsu_mem_rsp, m_lsu_rsp);
      check("mdl_cnt", outstanding_cnt, m_out);
      check("mdl_underflow", rsp_underflow, m_uflow);

      if (!reset) begin
         dec = mem_rsp.vld;
         if (acc) void'(m_slot.pop_front());
         if (exp_lg) m_slot.push_back(lsu_mem_req);
         else if (exp_ig) m_slot.push_back(icache_mem_req);
         if (!lsu_mem_req.vld || exp_lg) m_starve = 0;
         else if (exp_ig && m_starve < STARVE_LIMIT) m_starve++;
         if (dec && m_out == 0) m_uflow = 1;
         m_out = m_out + int'(acc) - int'(dec);
         if (m_out < 0) m_out = 0;
         m_ic_rsp  = (dec && mem_rsp.access_id[ICACHE_ID_BIT]) ? mem_rsp : '0;
         m_lsu_rsp = (dec && !mem_rsp.access_id[ICACHE_ID_BIT]) ? mem_rsp : '0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      request_t rq;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sample();
      check("rst_mem_req", mem_req, 0);
      check("rst_cnt", outstanding_cnt, 0);
      check("rst_underflow", rsp_underflow, 0);

      // Single request, fabric always ready
      mem_req_grant = 1'b1;
      next_cycle(); icache_mem_req = mk(1'b0, 7'h40, 32'h1000, 32'h0);
      sample();
      check("t1_ic_grant_c0", icache_req_grant, 1);
      check("t1_memreq_vld_c0", mem_req.vld, 0);
      next_cycle(); icache_mem_req = '0;
      sample();
      check("t1_memreq_vld_c1", mem_req.vld, 1);
      check("t1_memreq_addr_c1", mem_req.addr, 32'h1000);
      next_cycle(); sample();
      check("t1_memreq_vld_c2", mem_req.vld, 0);
      check("t1_cnt_c2", outstanding_cnt, 1);
      next_cycle(); mem_rsp = mk(1'b0, 7'h40, 32'h1000, 32'hAAAA);
      next_cycle(); mem_rsp = '0;
      sample();
      check("t1_ic_rsp_vld", icache_mem_rsp.vld, 1);
      check("t1_cnt_after_rsp", outstanding_cnt, 0);

      // Stall for 5 cycles, then back-to-back LSU load
      mem_req_grant = 1'b0;
      next_cycle(); icache_mem_req = mk(1'b0, 7'h41, 32'h2000, 32'h0);
      sample();
      check("t2_ic_grant", icache_req_grant, 1);
      next_cycle();
      icache_mem_req = '0;
      lsu_mem_req    = mk(1'b1, 7'h05, 32'h3000, 32'hBEEF);
      for (int i = 0; i < 5; i++) begin
         sample();
         check("t2_stall_hold", mem_req, mk(1'b0, 7'h41, 32'h2000, 32'h0));
         check("t2_stall_lsu_grant", lsu_req_grant, 0);
         next_cycle();
      end
      mem_req_grant = 1'b1;
      sample();
      check("t2_b2b_lsu_grant", lsu_req_grant, 1);
      next_cycle(); lsu_mem_req = '0;
      sample();
      check("t2_b2b_memreq", mem_req, mk(1'b1, 7'h05, 32'h3000, 32'hBEEF));
      next_cycle(); sample();
      check("t2_empty", mem_req.vld, 0);
      check("t2_cnt", outstanding_cnt, 2);

      // Routing: icache-tagged then LSU-tagged response
      next_cycle(); mem_rsp = mk(1'b0, 7'h40, 32'h0, 32'h11);
      next_cycle(); mem_rsp = mk(1'b0, 7'h05, 32'h0, 32'h22);
      sample();
      check("t5_ic_rsp", icache_mem_rsp, mk(1'b0, 7'h40, 32'h0, 32'h11));
      check("t5_lsu_idle", lsu_mem_rsp, 0);
      next_cycle(); mem_rsp = '0;
      sample();
      check("t5_lsu_rsp", lsu_mem_rsp, mk(1'b0, 7'h05, 32'h0, 32'h22));
      check("t5_ic_idle", icache_mem_rsp, 0);
      check("t5_cnt", outstanding_cnt, 0);

      // Anti-starvation: both always valid, responses follow acceptances by one cycle
      next_cycle();
      icache_mem_req = mk(1'b0, 7'h46, 32'h6000, 32'h0);
      lsu_mem_req    = mk(1'b0, 7'h07, 32'h7000, 32'h0);
      for (int i = 0; i < 27; i++) begin
         mem_rsp = (i >= 2) ? mk(1'b0, 7'h07, 32'h0, 32'h0) : '0;
         sample();
         check("t3_grant_seq", {icache_req_grant, lsu_req_grant},
               ((i % 9) == 8) ? 2'b01 : 2'b10);
         next_cycle();
      end
      icache_mem_req = '0;
      lsu_mem_req    = '0;
      mem_rsp        = mk(1'b0, 7'h07, 32'h0, 32'h0);
      next_cycle();
      mem_rsp = mk(1'b0, 7'h07, 32'h0, 32'h0);
      next_cycle(); mem_rsp = '0;
      sample();
      check("t3_drained_cnt", outstanding_cnt, 0);
      check("t3_drained_slot", mem_req.vld, 0);

      // Throttle at MAX_OUT outstanding
      next_cycle(); icache_mem_req = mk(1'b0, 7'h42, 32'h4000, 32'h0);
      for (int i = 0; i < 4; i++) begin
         sample();
         check("t4_issue_grant", icache_req_grant, 1);
         next_cycle();
      end
      icache_mem_req = '0;
      sample();
      check("t4_slot_4th", mem_req.vld, 1);
      check("t4_cnt3", outstanding_cnt, 3);
      next_cycle(); icache_mem_req = mk(1'b0, 7'h42, 32'h4100, 32'h0);
      sample();
      check("t4_blocked_grant", icache_req_grant, 0);
      check("t4_cnt_full", outstanding_cnt, 4);
      check("t4_slot_empty", mem_req.vld, 0);
      next_cycle(); sample();
      check("t4_blocked_grant2", icache_req_grant, 0);
      next_cycle(); mem_rsp = mk(1'b0, 7'h42, 32'h0, 32'h0);
      sample();
      check("t4_same_cycle_rsp_blocked", icache_req_grant, 0);
      next_cycle(); mem_rsp = '0;
      sample();
      check("t4_cnt_after_rsp", outstanding_cnt, 3);
      check("t4_unblocked_grant", icache_req_grant, 1);
      next_cycle(); icache_mem_req = '0;
      sample();
      check("t4_5th_issued", mem_req, mk(1'b0, 7'h42, 32'h4100, 32'h0));
      for (int i = 0; i < 4; i++) begin
         next_cycle(); mem_rsp = mk(1'b0, 7'h42, 32'h0, 32'h0);
      end
      next_cycle(); mem_rsp = '0;
      sample();
      check("t4_drained_cnt", outstanding_cnt, 0);

      // Reset while FULL, then an unexpected response
      mem_req_grant = 1'b0;
      next_cycle(); icache_mem_req = mk(1'b0, 7'h43, 32'h5000, 32'h0);
      sample();
      check("t6_ic_grant", icache_req_grant, 1);
      next_cycle(); icache_mem_req = mk(1'b0, 7'h44, 32'h5100, 32'h0);
      #1;
      check("t6_full_before_rst", mem_req.vld, 1);
      reset = 1'b1;
      #1;
      rq = mem_req;
      check("t6_rst_mem_req", rq, 0);
      check("t6_rst_ic_grant", icache_req_grant, 0);
      check("t6_rst_lsu_grant", lsu_req_grant, 0);
      check("t6_rst_cnt", outstanding_cnt, 0);
      next_cycle();
      reset          = 1'b0;
      icache_mem_req = '0;
      mem_rsp        = mk(1'b0, 7'h05, 32'h0, 32'h33);
      next_cycle(); mem_rsp = '0;
      sample();
      check("t6_underflow", rsp_underflow, 1);
      check("t6_cnt_hold0", outstanding_cnt, 0);
      next_cycle(); sample();
      check("t6_underflow_sticky", rsp_underflow, 1);

      repeat (2) next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_mem_port_scheduler.md
Name: core_mem_port_scheduler

Overview:
- Shares the core's single memory request port between the instruction cache and the vector load/store unit.
- Holds the winning request in an output slot until the memory fabric grants it.
- Uses weighted priority so the icache is favoured but the LSU cannot starve.
- Tracks outstanding transactions and routes memory responses back to the right requester.
- Sits between the core's requesters and the memory fabric.
- Replaces the core's priority arbiter, its request register and its response demux.

Parameters:
- STARVE_LIMIT, 8: maximum consecutive icache grants while the LSU is waiting.
- MAX_OUTSTANDING, 64: maximum accepted requests without a response. Counter width is $clog2(MAX_OUTSTANDING+1).
- ICACHE_ID_BIT, 6: the access_id bit that marks an icache transaction.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous reset, active-high.
- icache_mem_req  input  request_t  icache request; .vld qualifies it.
- icache_req_grant  output  1  icache request latched this cycle.
- lsu_mem_req  input  request_t  load/store unit request; .vld qualifies it.
- lsu_req_grant  output  1  LSU request latched this cycle.
- mem_req  output  request_t  registered request to memory.
- mem_req_grant  input  1  memory accepts mem_req this cycle.
- mem_rsp  input  request_t  memory response; .vld qualifies it.
- icache_mem_rsp  output  request_t  registered icache response.
- lsu_mem_rsp  output  request_t  registered LSU response.
- outstanding_cnt  output  $clog2(MAX_OUTSTANDING+1)  requests issued without a response.
- rsp_underflow  output  1  sticky: a response arrived with outstanding_cnt==0.

Behaviour:
- Reset values: mem_req=0, icache_mem_rsp=0, lsu_mem_rsp=0, outstanding_cnt=0, rsp_underflow=0, starve counter=0. Both grants are deasserted during reset.
- Reset mid-operation: any held slot is dropped silently. Requesters must reissue.
- Slot FSM, EMPTY:
  - mem_req.vld=0.
  - A granted requester moves the slot to FULL.
- Slot FSM, FULL:
  - mem_req holds stable until mem_req_grant=1.
  - On grant with a new winner: reload the slot and stay FULL (back-to-back, no bubble).
  - On grant with no winner: go to EMPTY, mem_req=0.
- Slot can load when state==EMPTY, or when FULL && mem_req_grant.
- Throttle: no load when outstanding_cnt==MAX_OUTSTANDING. This check uses the registered count, so a same-cycle response does not unblock it.
- Winner selection (combinational):
  - LSU wins if lsu.vld && (!icache.vld || starve==STARVE_LIMIT).
  - Otherwise icache wins if icache.vld.
- Grant timing:
  - *_req_grant is high in the cycle the winner is latched, and only while the slot can load.
  - A requester holds its request stable until granted and may change it the next cycle.
- Starve counter:
  - +1 when the icache is latched while lsu.vld=1.
  - Cleared when the LSU is latched, or when lsu.vld=0.
  - Saturates at STARVE_LIMIT.
- Outstanding counter:
  - Every accepted request (mem_req.vld && mem_req_grant) produces exactly one response; writes are acknowledged.
  - +1 on acceptance, -1 on mem_rsp.vld. Both in the same cycle leaves it unchanged.
  - A decrement at 0 holds at 0 and sets rsp_underflow.
- Response routing:
  - Latency is 1 cycle.
  - mem_rsp.access_id[ICACHE_ID_BIT]=1 goes to icache_mem_rsp, else to lsu_mem_rsp.
  - The non-selected output and both outputs on an idle cycle are driven to 0.
  - Responses are never back-pressured.

Decomposition:
- Shared package core_pkg:
  - request_t and its access_id layout.
  - ICACHE_ID_BIT.
  - MEM_REQ_PER_CORE.
  - A named constant for the default MAX_OUTSTANDING.
- Sub-module mem_rsp_router: the registered response demux plus underflow detection.
- Arbitration, the slot FSM and the counters stay in the top module.

Test Plan:
- Single request: icache.vld once, mem_req_grant tied 1.
  - icache_req_grant in cycle 0; mem_req.vld in cycle 1; slot empty in cycle 2.
- Stall and back-to-back: slot FULL, mem_req_grant=0 for 5 cycles, then 1 with the LSU pending.
  - mem_req stays stable for 5 cycles.
  - The LSU loads in the grant cycle with no idle cycle.
- Anti-starvation: both requesters valid continuously, grant=1.
  - Exactly 8 icache grants, then 1 LSU grant, then the pattern repeats.
- Throttle: MAX_OUTSTANDING=4, issue 4 with no responses.
  - 5th request blocked and no grant while cnt==4.
  - After a response, cnt drops to 3 and the 5th request issues the next cycle.
- Routing: mem_rsp with access_id=7'h40, then 7'h05.
  - icache_mem_rsp valid one cycle later, then lsu_mem_rsp; the other output is 0 each time.
- Reset and underflow: assert reset while FULL.
  - All outputs become 0 immediately.
  - A response after reset sets rsp_underflow, and cnt stays 0.
